// File: rtl/button_pkg.sv
// Shared types and constants for the pushbutton conditioner.
// Auto-repeat is compiled in only when BUTTON_AUTOREPEAT_EN is defined.
package button_pkg;

  typedef enum logic [1:0] {
    REL = 2'd0,
    PW  = 2'd1,
    PRS = 2'd2,
    RW  = 2'd3
  } db_state_e;

  localparam int DB_CYCLES_DEF  = 1048576;
  localparam int REP_DELAY_DEF  = 16777216;
  localparam int REP_PERIOD_DEF = 4194304;

  // Shortened timing so simulations finish in a few thousand cycles
  localparam int SIM_DB_CYCLES  = 8;
  localparam int SIM_REP_DELAY  = 32;
  localparam int SIM_REP_PERIOD = 16;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with stable-cycle
// counter, registered level/strobes, and auto-repeat under BUTTON_AUTOREPEAT_EN.
module debounce_ch
  import button_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_PERIOD = REP_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  if (DB_CYCLES < 2 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_param
    $error("debounce_ch: DB_CYCLES must be >= 2 and REP_* >= 1");
  end

  logic             sync1_q, sync2_q;
  logic             s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             cnt_last;

  assign s        = ~sync2_q;
  assign cnt_last = (cnt_q == CNT_W'(DB_CYCLES - 1));

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int REP_W = $clog2(max_i(max_i(REP_DELAY, REP_PERIOD), 2));
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             rep_hit;
  assign rep_hit = rep_first_q ? (rep_cnt_q == REP_W'(REP_DELAY - 1))
                               : (rep_cnt_q == REP_W'(REP_PERIOD - 1));
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      REL: begin
        if (s) begin
          state_d = PW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      PW: begin
        if (!s) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = PRS;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRS: begin
        if (!s) begin
          state_d = RW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      RW: begin
        if (s) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_last) begin
          state_d = REL;
          cnt_d   = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase

`ifdef BUTTON_AUTOREPEAT_EN
    // Counter restarts only on a fresh accept; a release bounce back into
    // PRS resumes where it left off.
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    if (state_q == PW && state_d == PRS) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (state_q == PRS && s) begin
      if (rep_hit) begin
        press_d     = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
`endif

    level_d = (state_d == PRS) || (state_d == RW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= REL;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= pin_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton front end: N_BTN independent debounce channels plus an any_press OR.
// Optional auto-repeat is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN      = 4,
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int REP_DELAY  = REP_DELAY_DEF,
  parameter int REP_PERIOD = REP_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] inpulse,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .pin_n(inpulse[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model predicts
// each cycle's outputs into a queue; a monitor pops and compares after each edge.
module tb_button_conditioner;
  import button_pkg::*;

  localparam int N  = 4;
  localparam int DB = SIM_DB_CYCLES;
  localparam int RD = SIM_REP_DELAY;
  localparam int RP = SIM_REP_PERIOD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] inpulse = '1;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         any_press;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic         any;
  } exp_t;

  exp_t exp_q[$];

  button_conditioner #(
    .N_BTN(N), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .inpulse(inpulse),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .any_press(any_press)
  );

  always #5 clk = ~clk;

  // Reference model: the filter sees the pin two samples late; a level
  // change is accepted once the (inverted) pin has disagreed with the
  // accepted level for DB consecutive cycles.
  logic [N-1:0] pin_dly [2];
  bit           m_lvl   [N];
  int           m_run   [N];
  int           m_hold  [N];
  bit           m_first [N];

  always @(posedge clk) begin
    exp_t e;
    logic [N-1:0] s;
    e = '0;
    if (rst) begin
      pin_dly[0] = '1;
      pin_dly[1] = '1;
      for (int i = 0; i < N; i++) begin
        m_lvl[i] = 0; m_run[i] = 0; m_hold[i] = 0; m_first[i] = 1;
      end
    end else begin
      s = ~pin_dly[1];
      for (int i = 0; i < N; i++) begin
`ifdef BUTTON_AUTOREPEAT_EN
        if (m_lvl[i] && m_run[i] == 0 && s[i]) begin
          m_hold[i]++;
          if (m_hold[i] == (m_first[i] ? RD : RP)) begin
            e.press[i] = 1'b1;
            m_hold[i]  = 0;
            m_first[i] = 0;
          end
        end
`endif
        if (s[i] != m_lvl[i]) m_run[i]++;
        else                  m_run[i] = 0;
        if (m_run[i] == DB) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          if (m_lvl[i]) begin
            e.press[i] = 1'b1;
            m_hold[i]  = 0;
            m_first[i] = 1;
          end else begin
            e.rel[i] = 1'b1;
          end
        end
      end
      pin_dly[1] = pin_dly[0];
      pin_dly[0] = inpulse;
    end
    for (int i = 0; i < N; i++) e.level[i] = m_lvl[i];
    e.any = |e.press;
    exp_q.push_back(e);
  end

  // Monitor
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    a = '{level: btn_level, press: btn_press, rel: btn_release, any: any_press};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t got=%h", $time, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        if (n_fail < 40)
          $display("FAIL outputs t=%0t got lvl=%b prs=%b rel=%b any=%b need lvl=%b prs=%b rel=%b any=%b",
                   $time, a.level, a.press, a.rel, a.any, e.level, e.press, e.rel, e.any);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pin(input int ch, input logic v);
    @(negedge clk);
    inpulse[ch] = v;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed latency check: edge count from a pin change to btn_press[ch]
  task automatic check_press_latency(input int ch, input string name);
    int k;
    bit seen;
    k = 0;
    seen = 0;
    while (!seen && k < 3 * DB) begin
      @(posedge clk);
      #2;
      k++;
      if (btn_press[ch]) seen = 1;
    end
    n_checks++;
    if (!seen || k != DB + 2) begin
      n_fail++;
      $display("FAIL %s latency got=%0d (seen=%0d) need=%0d", name, k, seen, DB + 2);
    end
  endtask

  initial begin
    cyc(3);
    @(negedge clk) rst = 1'b0;
    cyc(20);

    // Clean press on channel 0 with exact-latency check
    @(negedge clk) inpulse[0] = 1'b0;
    check_press_latency(0, "ch0_press");
    cyc(15);
    set_pin(0, 1'b1);
    cyc(15);

    // Channel 1 bounce, then settle pressed
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i % 3 == 0) inpulse[1] = ~inpulse[1];
    end
    @(negedge clk) inpulse[1] = 1'b0;
    check_press_latency(1, "ch1_settle");
    cyc(15);
    set_pin(1, 1'b1);
    cyc(15);

    // Channel 2 press then release
    set_pin(2, 1'b0);
    cyc(15);
    set_pin(2, 1'b1);
    cyc(15);

    // Simultaneous press on 0 and 3, reset while held, re-accept
    @(negedge clk) begin inpulse[0] = 1'b0; inpulse[3] = 1'b0; end
    cyc(15);
    pulse_rst();
    cyc(15);
    @(negedge clk) begin inpulse[0] = 1'b1; inpulse[3] = 1'b1; end
    cyc(15);

    // Reset in the middle of a debounce window
    set_pin(2, 1'b0);
    cyc(4);
    pulse_rst();
    cyc(15);
    set_pin(2, 1'b1);
    cyc(15);

    // Long hold (auto-repeat window when enabled)
    set_pin(0, 1'b0);
    cyc(DB + 2 + 100);
    set_pin(0, 1'b1);
    cyc(15);

    // Random bouncy traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) inpulse[i] = ~inpulse[i];
      if ($urandom_range(0, 199) == 0) inpulse = '1;
    end
    @(negedge clk) begin rst = 1'b0; inpulse = '1; end
    cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
